// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous test-pattern sequencer: 25 MHz pixel enable, vsync frame
// detection, debounced key and auto-advance, pattern changes only at frame starts.
module vga_pattern_sequencer #(
   parameter int NUM_PAT      = 8,
   parameter int AUTO_FRAMES  = 60,
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        vsync,
   input  logic        key_n,
   input  logic        auto_en,
   output logic        pix_en,
   output logic [2:0]  pat_sel,
   output logic        frame_start,
   output logic [15:0] frame_cnt,
   output logic        pending
);

   localparam int DCW = $clog2(DEBOUNCE_CYC);
   localparam int ACW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

   localparam logic [DCW-1:0] DEB_LAST  = DCW'(DEBOUNCE_CYC - 1);
   localparam logic [ACW-1:0] AUTO_LAST = ACW'(AUTO_FRAMES - 1);
   localparam logic [2:0]     PAT_LAST  = 3'(NUM_PAT - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_PEND = 1'b1
   } state_t;

   state_t         state;

   logic           vs_meta;
   logic           vs_sync;
   logic           vs_prev;
   logic           vs_fall;

   logic           key_meta;
   logic           key_sync;
   logic           key_db;
   logic           press_evt;
   logic [DCW-1:0] deb_cnt;

   logic [ACW-1:0] auto_cnt;
   logic           auto_evt;
   logic           advance;

   // NOTE: sequential state is only ever written with <= so every flop samples
   // the pre-edge value of its neighbours, regardless of block ordering.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pix_en <= 1'b0;
      end else begin
         pix_en <= ~pix_en;
      end
   end

   // Synchronisers reset to the idle (high) level so release of reset is not
   // mistaken for a vsync fall or a key press.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         vs_meta  <= 1'b1;
         vs_sync  <= 1'b1;
         vs_prev  <= 1'b1;
         key_meta <= 1'b1;
         key_sync <= 1'b1;
      end else begin
         vs_meta  <= vsync;
         vs_sync  <= vs_meta;
         vs_prev  <= vs_sync;
         key_meta <= key_n;
         key_sync <= key_meta;
      end
   end

   assign vs_fall = vs_prev & ~vs_sync;

   // Debounced level flips after DEBOUNCE_CYC consecutive disagreeing samples.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_db    <= 1'b1;
         deb_cnt   <= '0;
         press_evt <= 1'b0;
      end else begin
         press_evt <= 1'b0;
         if (key_sync == key_db) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            key_db    <= key_sync;
            deb_cnt   <= '0;
            press_evt <= ~key_sync;
         end else begin
            deb_cnt <= deb_cnt + DCW'(1);
         end
      end
   end

   assign auto_evt = auto_en & vs_fall & (auto_cnt == AUTO_LAST);
   assign advance  = (state == S_PEND) & vs_fall;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         auto_cnt <= '0;
      end else if (advance || !auto_en) begin
         auto_cnt <= '0;
      end else if (vs_fall && (auto_cnt != AUTO_LAST)) begin
         auto_cnt <= auto_cnt + ACW'(1);
      end
   end

   // An event seen in S_IDLE on a frame edge only arms; the advance waits for
   // the next frame so the current frame is never split.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= S_IDLE;
         pending     <= 1'b0;
         pat_sel     <= 3'd0;
         frame_start <= 1'b0;
         frame_cnt   <= 16'd0;
      end else begin
         frame_start <= vs_fall;
         if (vs_fall) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         case (state)
            S_IDLE: begin
               if (press_evt || auto_evt) begin
                  state   <= S_PEND;
                  pending <= 1'b1;
               end
            end
            S_PEND: begin
               if (vs_fall) begin
                  state   <= S_IDLE;
                  pending <= 1'b0;
                  pat_sel <= (pat_sel >= PAT_LAST) ? 3'd0 : pat_sel + 3'd1;
               end
            end
            default: begin
               state   <= S_IDLE;
               pending <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Bench for vga_pattern_sequencer: reset/bounce vector table, directed frame
// corner cases, then randomized inputs against a history-based reference model.
module tb_vga_pattern_sequencer;

   localparam int NP = 4;
   localparam int AF = 3;
   localparam int D  = 4;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        vsync;
   logic        key_n;
   logic        auto_en;
   logic        pix_en;
   logic [2:0]  pat_sel;
   logic        frame_start;
   logic [15:0] frame_cnt;
   logic        pending;

   int checks = 0;
   int errors = 0;

   vga_pattern_sequencer #(
      .NUM_PAT      (NP),
      .AUTO_FRAMES  (AF),
      .DEBOUNCE_CYC (D)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .vsync       (vsync),
      .key_n       (key_n),
      .auto_en     (auto_en),
      .pix_en      (pix_en),
      .pat_sel     (pat_sel),
      .frame_start (frame_start),
      .frame_cnt   (frame_cnt),
      .pending     (pending)
   );

   always #10 sys_clk = ~sys_clk;

   // Reference model: keeps the per-edge input history and applies the rules
   // directly (debounce window, vsync fall seen two samples late, frame rules).
   bit          kq[$];
   bit          vq[$];
   bit          m_db;
   bit          m_press_q;
   int          m_acnt;
   bit          m_pend;
   int          m_pat;
   bit          m_fs;
   logic [15:0] m_fcnt;
   int          m_edges;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      kq = {};
      vq = {};
      for (int i = 0; i < D + 2; i++) kq.push_back(1'b1);
      for (int i = 0; i < 3; i++) vq.push_back(1'b1);
      m_db      = 1'b1;
      m_press_q = 1'b0;
      m_acnt    = 0;
      m_pend    = 1'b0;
      m_pat     = 0;
      m_fs      = 1'b0;
      m_fcnt    = 16'd0;
      m_edges   = 0;
   endtask

   task automatic model_edge();
      int  n;
      bit  fe;
      bit  press_now;
      bit  auto_evt;
      bit  adv;
      bit  all_diff;
      if (!sys_rst_n) begin
         model_reset();
         return;
      end
      kq.push_back(key_n);
      vq.push_back(vsync);
      if (kq.size() > D + 3) void'(kq.pop_front());
      if (vq.size() > 4) void'(vq.pop_front());
      n  = vq.size();
      fe = (vq[n-3] == 1'b0) && (vq[n-4] == 1'b1);
      press_now = m_press_q;
      n = kq.size();
      all_diff = 1'b1;
      for (int j = n - D - 2; j <= n - 3; j++)
         if (kq[j] == m_db) all_diff = 1'b0;
      m_press_q = 1'b0;
      if (all_diff) begin
         m_db      = !m_db;
         m_press_q = (m_db == 1'b0);
      end
      auto_evt = auto_en && fe && (m_acnt == AF - 1);
      adv      = m_pend && fe;
      if (adv) m_pat = (m_pat + 1) % NP;
      if (m_pend) begin
         if (fe) m_pend = 1'b0;
      end else if (press_now || auto_evt) begin
         m_pend = 1'b1;
      end
      if (adv || !auto_en) m_acnt = 0;
      else if (fe && m_acnt < AF - 1) m_acnt++;
      m_fs = fe;
      if (fe) m_fcnt = m_fcnt + 16'd1;
      m_edges++;
   endtask

   task automatic step(input bit cmp);
      @(posedge sys_clk);
      model_edge();
      #1;
      if (cmp) begin
         check("m_pix_en", pix_en, m_edges % 2);
         check("m_pat_sel", pat_sel, m_pat);
         check("m_frame_start", frame_start, m_fs);
         check("m_frame_cnt", frame_cnt, m_fcnt);
         check("m_pending", pending, m_pend);
      end
      @(negedge sys_clk);
   endtask

   task automatic check_state(input string tag, input int pat, input int pend, input int fcnt);
      check({tag, "_pat"}, pat_sel, pat);
      check({tag, "_pend"}, pending, pend);
      check({tag, "_fcnt"}, frame_cnt, fcnt);
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      vsync     = 1'b1;
      key_n     = 1'b1;
      auto_en   = 1'b0;
      step(0);
      step(0);
      sys_rst_n = 1'b1;
   endtask

   task automatic run_frame(input string tag);
      int pulses = 0;
      vsync = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(0);
         if (frame_start === 1'b1) pulses++;
      end
      vsync = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(0);
         if (frame_start === 1'b1) pulses++;
      end
      check({tag, "_fs_pulses"}, pulses, 1);
   endtask

   task automatic press();
      key_n = 1'b0;
      for (int i = 0; i < 8; i++) step(0);
      key_n = 1'b1;
      for (int i = 0; i < 8; i++) step(0);
   endtask

   // Key falls D cycles before vsync so the debounced press lands on the frame edge.
   task automatic press_at_frame(input string tag, input int pat, input int fcnt);
      key_n = 1'b0;
      for (int i = 0; i < D; i++) step(0);
      vsync = 1'b0;
      for (int i = 0; i < 3; i++) step(0);
      check({tag, "_fs"}, frame_start, 1);
      check_state(tag, pat, 1, fcnt);
      vsync = 1'b1;
      for (int i = 0; i < 5; i++) step(0);
      key_n = 1'b1;
      for (int i = 0; i < 8; i++) step(0);
   endtask

   typedef struct {
      bit vsync;
      bit key_n;
      bit auto_en;
      bit exp_pix;
      int exp_pat;
      bit exp_fs;
      int exp_fcnt;
      bit exp_pend;
   } vec_t;

   vec_t tbl[18];

   initial begin
      int vs_left;
      int key_left;

      // Rows 0..9 bounce the key every cycle; rows 10..17 hold it low.
      for (int i = 0; i < 18; i++) begin
         tbl[i].vsync    = 1'b1;
         tbl[i].key_n    = (i < 10) ? i[0] : 1'b0;
         tbl[i].auto_en  = 1'b0;
         tbl[i].exp_pix  = (i % 2 == 0);
         tbl[i].exp_pat  = 0;
         tbl[i].exp_fs   = 1'b0;
         tbl[i].exp_fcnt = 0;
         tbl[i].exp_pend = (i >= 16);
      end

      model_reset();
      sys_rst_n = 1'b0;
      vsync     = 1'b1;
      key_n     = 1'b1;
      auto_en   = 1'b0;
      step(0);
      step(0);
      check("rst_pix_en", pix_en, 0);
      check("rst_frame_start", frame_start, 0);
      check_state("rst", 0, 0, 0);
      sys_rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         vsync   = tbl[i].vsync;
         key_n   = tbl[i].key_n;
         auto_en = tbl[i].auto_en;
         step(0);
         check($sformatf("tbl%0d_pix", i), pix_en, tbl[i].exp_pix);
         check($sformatf("tbl%0d_fs", i), frame_start, tbl[i].exp_fs);
         check_state($sformatf("tbl%0d", i), tbl[i].exp_pat, tbl[i].exp_pend, tbl[i].exp_fcnt);
      end

      // Release generates no event; then the frame edge applies the press.
      step(0);
      key_n = 1'b1;
      for (int i = 0; i < 10; i++) step(0);
      vsync = 1'b0;
      step(0);
      step(0);
      check("bounce_fs_early", frame_start, 0);
      check("bounce_pat_early", pat_sel, 0);
      step(0);
      check("bounce_fs", frame_start, 1);
      check_state("bounce_adv", 1, 0, 1);
      step(0);
      check("bounce_fs_len", frame_start, 0);
      vsync = 1'b1;
      for (int i = 0; i < 5; i++) step(0);
      run_frame("noqueue");
      check_state("noqueue", 1, 0, 2);

      // Three presses in one frame advance once.
      press();
      press();
      press();
      check_state("three_pend", 1, 1, 2);
      run_frame("three");
      check_state("three_adv", 2, 0, 3);
      run_frame("three_after");
      check_state("three_after", 2, 0, 4);

      // Auto mode: AUTO_FRAMES+1 frame starts per pattern.
      do_reset();
      auto_en = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         run_frame("auto");
         check_state($sformatf("auto%0d", n), (n / (AF + 1)) % NP, (n % (AF + 1)) == AF, n);
      end

      // Press and auto event together, both on a frame edge.
      do_reset();
      auto_en = 1'b1;
      run_frame("coinc_a");
      run_frame("coinc_b");
      check_state("coinc_pre", 0, 0, 2);
      press_at_frame("coinc", 0, 3);
      run_frame("coinc_adv");
      check_state("coinc_adv", 1, 0, 4);
      run_frame("coinc_after");
      check_state("coinc_after", 1, 0, 5);

      // Press on a frame edge with auto mode off.
      auto_en = 1'b0;
      press_at_frame("keyfs", 1, 6);
      run_frame("keyfs_adv");
      check_state("keyfs_adv", 2, 0, 7);

      // Asynchronous reset while an advance is pending.
      do_reset();
      press();
      run_frame("rp1");
      press();
      run_frame("rp2");
      press();
      check_state("rp_pend", 2, 1, 2);
      sys_rst_n = 1'b0;
      #1;
      check("rp_async_pix", pix_en, 0);
      check("rp_async_fs", frame_start, 0);
      check_state("rp_async", 0, 0, 0);
      step(0);
      sys_rst_n = 1'b1;
      run_frame("rp_after");
      check_state("rp_after", 0, 0, 1);

      // Randomized traffic against the reference model.
      do_reset();
      auto_en  = 1'b1;
      vs_left  = 10;
      key_left = 5;
      for (int c = 0; c < 1500; c++) begin
         if (vs_left == 0) begin
            vsync   = !vsync;
            vs_left = vsync ? int'($urandom_range(4, 24)) : int'($urandom_range(2, 6));
         end
         vs_left--;
         if (key_left == 0) begin
            key_n    = !key_n;
            key_left = int'($urandom_range(1, 9));
         end
         key_left--;
         if ($urandom_range(0, 99) == 0) auto_en = !auto_en;
         if (c == 700) sys_rst_n = 1'b0;
         if (c == 703) sys_rst_n = 1'b1;
         step(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vga_pattern_sequencer.md
# vga_pattern_sequencer

Frame-synchronous controller for the VGA colour-bar datapath. It runs on sys_clk (50 MHz), issues the 25 MHz pixel clock-enable, and selects which test pattern the picture generator draws. Pattern changes come from a debounced push-button or an auto-advance frame counter, and are applied only at a frame boundary so no frame shows two patterns. It sits between the board inputs and the vga_ctrl/vga_pic pair, replacing the free-running clock divider.

## Interface
Parameters:
- NUM_PAT, 8: number of patterns, 1..8; pat_sel cycles 0..NUM_PAT-1.
- AUTO_FRAMES, 60: frames per pattern in auto mode, ≥1.
- DEBOUNCE_CYC, 1_000_000: sys_clk cycles key_n must stay stable, ≥2.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- vsync  in  1  field sync from vga_ctrl, active-low pulse; treated as asynchronous.
- key_n  in  1  push-button, active-low, bouncing.
- auto_en  in  1  level: 1 = auto-advance enabled.
- pix_en  out  1  pixel clock-enable, high every second sys_clk cycle.
- pat_sel  out  3  current pattern index.
- frame_start  out  1  one-cycle pulse per frame.
- frame_cnt  out  16  frames since reset, wraps 0xFFFF→0.
- pending  out  1  advance requested, not yet applied.

## Operation
- Reset values: pix_en=0, pat_sel=0, frame_start=0, frame_cnt=0, pending=0. Debounce, sync and auto counters clear. State is S_IDLE.
- pix_en: toggles every sys_clk edge, so the first high is the cycle after reset release. Duty is 50%.
- vsync path: a 2-flop synchroniser feeds a falling-edge detect. frame_start is a registered pulse on that edge.
- Debouncer: key_n is synchronised by 2 flops. The input is stable once it holds the same level for DEBOUNCE_CYC consecutive cycles. A press event is the transition of the debounced level 1→0, giving one event per physical press. Release generates no event.
- Auto counter: counts frame_start pulses while auto_en=1. It is held at 0 while auto_en=0. An auto event fires on the frame_start where count reaches AUTO_FRAMES-1. Every pattern advance clears the counter.
- FSM:
  - S_IDLE: pending=0. Any press or auto event → S_PEND.
  - S_PEND: pending=1. On the next frame_start, pat_sel advances by one, wrapping NUM_PAT-1→0, then → S_IDLE.
- Press and auto event in the same cycle: one advance only.
- Events arriving while in S_PEND are absorbed, not queued.
- Event in the same cycle as frame_start while in S_IDLE: goes to S_PEND; the advance happens on the following frame_start, not this one.
- Auto event in S_IDLE: takes effect on the following frame_start, so an auto-run frame holds AUTO_FRAMES+1 frames. This is the defined behaviour.
- NUM_PAT=1: pat_sel stays 0. Events still cycle the FSM.
- frame_cnt increments on every frame_start, independent of the FSM.
- auto_en falling while in S_PEND: the pending advance is still applied.
- Asynchronous reset mid-operation returns every register to its reset value immediately. A partial debounce count is discarded.

## Timing
- vsync falling at the input → frame_start high 3 sys_clk edges later (2 sync + 1 register), for exactly 1 cycle.
- pat_sel and frame_cnt update on the same edge that asserts frame_start. pending drops on that edge too.
- Key press: debounced event occurs 2 + DEBOUNCE_CYC cycles after key_n settles low. pending rises 1 cycle after the event.
- The pattern becomes visible on the next full frame, because vsync starts the vertical blank.
- vsync pulses shorter than 2 sys_clk cycles may be missed. vga_ctrl guarantees a multi-line pulse.

## Test plan
Parameters for the bench: NUM_PAT=4, AUTO_FRAMES=3, DEBOUNCE_CYC=4, with short synthetic frames.
- Reset, then release: pix_en pattern 1,0,1,0… from the first cycle after release; all other outputs 0.
- key_n bounces 0/1 every cycle for 10 cycles, then holds 0 for 8 cycles: exactly one event, pending=1; at the next vsync fall pat_sel 0→1, frame_start +3 cycles, pending=0.
- Three presses within one frame: pat_sel advances once only (1→2).
- auto_en=1, no key: pat_sel steps 0→1→2→3→0 every 4 frame_starts; frame_cnt matches the pulse count.
- Press and auto event in the same cycle: single advance. A press in the same cycle as frame_start: advance lands on the next frame_start.
- Assert sys_rst_n=0 while pending=1 with pat_sel=2: outputs go to 0 asynchronously; after release, no advance occurs on the next frame.
